// File: rtl/mole_spawner.sv
// -----------------------------------------------------------------------------
// mole_spawner
//
// Purpose:
//   Game-play stage for the whack-a-mole board. Uses the free-running value
//   from the rng block to pick the idle gap before each mole and the LED it
//   appears on. It scores debounced whacks, counts misses (expiries plus wrong
//   whacks) and ends the game once the miss count reaches MAX_MISSES. Each
//   correct hit shortens the mole lifetime, down to a floor.
//
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   start         in   one-cycle pulse; clears score/misses, starts a game
//   enable        in   level; low forces IDLE and freezes score/misses
//   random_value  in   [W-1:0] random value from the rng block
//   hit_valid     in   one-cycle debounced whack pulse
//   hit_index     in   [4:0] mole targeted by the whack
//   mole_leds     out  [NUM_MOLES-1:0] one-hot lit mole, zero when none is up
//   mole_active   out  high while a mole is up
//   score         out  [7:0] successful hits, saturating at 255
//   misses        out  [7:0] expiries plus wrong whacks
//   game_over     out  high once the miss limit has been reached
// -----------------------------------------------------------------------------
module mole_spawner #(
  parameter int NUM_MOLES    = 18,     // 2..32
  parameter int TICKS_PER_MS = 50000,
  parameter int MAX_MS       = 2047,
  parameter int MIN_GAP_MS   = 200,    // >= 1
  parameter int LIFE_MS      = 1000,
  parameter int LIFE_STEP_MS = 50,
  parameter int MIN_LIFE_MS  = 250,
  parameter int MAX_MISSES   = 3,
  // Width of the ms counter, lifetime and random_value. Must be >= 5 because
  // the mole position is taken from random_value[4:0].
  localparam int W           = $clog2(MAX_MS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 enable,
  input  logic [W-1:0]         random_value,
  input  logic                 hit_valid,
  input  logic [4:0]           hit_index,
  output logic [NUM_MOLES-1:0] mole_leds,
  output logic                 mole_active,
  output logic [7:0]           score,
  output logic [7:0]           misses,
  output logic                 game_over
);

  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_SPAWN,
    S_UP,
    S_OVER
  } state_t;

  state_t                 state_q,       state_d;
  logic [PW-1:0]          presc_q,       presc_d;
  logic [W-1:0]           ms_q,          ms_d;
  logic [4:0]             pos_q,         pos_d;
  logic [W-1:0]           lifetime_q,    lifetime_d;
  logic [7:0]             score_q,       score_d;
  logic [7:0]             misses_q,      misses_d;
  logic [NUM_MOLES-1:0]   mole_leds_q,   mole_leds_d;
  logic                   mole_active_q, mole_active_d;
  logic                   game_over_q,   game_over_d;

  logic                   in_run;
  logic                   ms_tick;
  logic [W:0]             gap_sum;
  logic [W-1:0]           gap_load;
  logic [4:0]             pos_raw;
  logic [4:0]             pos_wrap;
  logic                   hit_match;
  logic [7:0]             score_sat;
  logic [7:0]             misses_inc;
  logic [W-1:0]           lifetime_dec;
  logic [NUM_MOLES-1:0]   pos_onehot;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  // The prescaler only runs while a timed state is active.
  assign in_run  = (state_q == S_GAP) || (state_q == S_UP);
  assign ms_tick = in_run && (presc_q == PW'(TICKS_PER_MS - 1));

  // Gap length: MIN_GAP_MS + random_value, one bit wider so the sum cannot
  // wrap, then clamped to MAX_MS.
  assign gap_sum  = {1'b0, random_value} + (W+1)'(MIN_GAP_MS);
  assign gap_load = (gap_sum > (W+1)'(MAX_MS)) ? W'(MAX_MS) : gap_sum[W-1:0];

  // A 5-bit value is below 2*NUM_MOLES for the supported sizes of interest,
  // so a single conditional subtraction folds it into range.
  assign pos_raw  = random_value[4:0];
  assign pos_wrap = ({27'd0, pos_raw} >= NUM_MOLES) ? (pos_raw - 5'(NUM_MOLES)) : pos_raw;

  // Out-of-range indices are rejected explicitly so they can never alias.
  assign hit_match = (hit_index == pos_q) && ({27'd0, hit_index} < NUM_MOLES);

  assign score_sat  = (score_q  == 8'hFF) ? score_q  : score_q  + 8'd1;
  assign misses_inc = (misses_q == 8'hFF) ? misses_q : misses_q + 8'd1;

  assign lifetime_dec = (int'(lifetime_q) >= (MIN_LIFE_MS + LIFE_STEP_MS))
                        ? (lifetime_q - W'(LIFE_STEP_MS))
                        : W'(MIN_LIFE_MS);

  // One-hot decode of the next position, one comparator per LED.
  for (genvar gi = 0; gi < NUM_MOLES; gi++) begin : g_onehot
    assign pos_onehot[gi] = (pos_d == 5'(gi));
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    ms_d       = ms_q;
    pos_d      = pos_q;
    lifetime_d = lifetime_q;
    score_d    = score_q;
    misses_d   = misses_q;

    if (!enable) begin
      // Pause: everything except the state holds; start is ignored.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            score_d    = '0;
            misses_d   = '0;
            lifetime_d = W'(LIFE_MS);
            state_d    = S_GAP;
          end
        end

        S_GAP: begin
          if (ms_q == '0) begin
            state_d = S_SPAWN;
          end else if (ms_tick) begin
            ms_d = ms_q - 1'b1;
          end
        end

        S_SPAWN: begin
          pos_d   = pos_wrap;
          ms_d    = lifetime_q;
          state_d = S_UP;
        end

        S_UP: begin
          // The lifetime keeps running through a wrong whack.
          if (ms_tick && (ms_q != '0)) begin
            ms_d = ms_q - 1'b1;
          end
          if (hit_valid && hit_match) begin
            // A correct hit wins even on the expiry cycle.
            score_d    = score_sat;
            lifetime_d = lifetime_dec;
            state_d    = S_GAP;
          end else if (hit_valid || (ms_q == '0)) begin
            // Wrong whack (mole stays up) or expiry (mole goes down).
            misses_d = misses_inc;
            if (misses_inc >= 8'(MAX_MISSES)) begin
              state_d = S_OVER;
            end else if (!hit_valid) begin
              state_d = S_GAP;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    // Prescaler restarts on every state change so each state times from zero.
    if (state_d != state_q) begin
      presc_d = '0;
    end else if (in_run) begin
      presc_d = ms_tick ? '0 : (presc_q + 1'b1);
    end

    // Every entry into GAP draws a fresh random gap.
    if ((state_d == S_GAP) && (state_q != S_GAP)) begin
      ms_d = gap_load;
    end
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with state_q and never see a combinational path from the inputs.
  assign mole_leds_d   = (state_d == S_UP) ? pos_onehot : '0;
  assign mole_active_d = (state_d == S_UP);
  assign game_over_d   = (state_d == S_OVER);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      presc_q       <= '0;
      ms_q          <= '0;
      pos_q         <= '0;
      lifetime_q    <= W'(LIFE_MS);
      score_q       <= '0;
      misses_q      <= '0;
      mole_leds_q   <= '0;
      mole_active_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      ms_q          <= ms_d;
      pos_q         <= pos_d;
      lifetime_q    <= lifetime_d;
      score_q       <= score_d;
      misses_q      <= misses_d;
      mole_leds_q   <= mole_leds_d;
      mole_active_q <= mole_active_d;
      game_over_q   <= game_over_d;
    end
  end

  assign mole_leds   = mole_leds_q;
  assign mole_active = mole_active_q;
  assign score       = score_q;
  assign misses      = misses_q;
  assign game_over   = game_over_q;

endmodule

// File: doc/mole_spawner.md
Name: mole_spawner

Overview:
- Game-play stage downstream of the rng module. It consumes random_value to choose where and when moles appear, and drives the LEDR mole field.
- Accepts debounced whack attempts, tracks score and misses, and ends the game after a fixed number of misses.
- Runs on the board clock and uses its own millisecond prescaler.

Parameters:
NUM_MOLES, 18, number of mole LEDs; range 2..32
TICKS_PER_MS, 50000, clk cycles per millisecond tick
MAX_MS, 2047, maximum gap/lifetime in ms; sets the ms counter width W = $clog2(MAX_MS)
MIN_GAP_MS, 200, minimum idle gap between moles; must be >= 1
LIFE_MS, 1000, initial mole lifetime in ms
LIFE_STEP_MS, 50, lifetime reduction per successful hit
MIN_LIFE_MS, 250, lifetime floor
MAX_MISSES, 3, miss count that ends the game

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: clears score/misses and begins a game
enable  in  1  level; low pauses play and forces IDLE
random_value  in  W  free-running random value from rng
hit_valid  in  1  one-cycle debounced whack pulse
hit_index  in  5  mole targeted by the whack
mole_leds  out  NUM_MOLES  one-hot active mole; all zero when no mole is up
mole_active  out  1  high while in UP
score  out  8  successful hits; saturates at 255
misses  out  8  expiries plus wrong whacks
game_over  out  1  high in OVER

Behaviour:
- Reset (async, reset_n low): state = IDLE; all outputs 0; prescaler, ms counter and position = 0; lifetime = LIFE_MS.
- Prescaler:
  - Counts 0..TICKS_PER_MS-1 only in GAP and UP; ms_tick is high on the terminal count.
  - Cleared on every state entry.
- States:
  - IDLE: wait for start with enable high. On start: score = 0, misses = 0, lifetime = LIFE_MS, go to GAP.
  - GAP:
    - On entry, the ms counter loads min(MIN_GAP_MS + random_value, MAX_MS), computed with W+1 bits and then saturated.
    - Counter decrements on each ms_tick. When it reaches 0, go to SPAWN on the next cycle.
  - SPAWN (exactly 1 cycle):
    - Latch pos = random_value[4:0]; if pos >= NUM_MOLES, subtract NUM_MOLES (one subtraction, no divider).
    - Load ms counter with lifetime; go to UP.
  - UP: mole_leds = 1 << pos; mole_active = 1. Same-cycle priority, highest first:
    1. hit_valid && hit_index == pos: score + 1 (saturating); lifetime = max(lifetime - LIFE_STEP_MS, MIN_LIFE_MS); go to GAP.
    2. hit_valid && hit_index != pos: misses + 1; mole stays up; counter continues.
    3. Counter reaches 0: misses + 1; go to GAP.
    - A correct hit on the same cycle as expiry counts as a hit, not a miss.
    - After any miss increment, if misses == MAX_MISSES, go to OVER instead of GAP/UP.
  - OVER: mole_leds = 0; game_over = 1; score and misses hold. start goes to GAP with the same clears as from IDLE.
- hit_valid outside UP is ignored (no score or miss change).
- enable low: from any state, the next state is IDLE; mole_leds clear; score/misses/lifetime hold. start is ignored while enable is low.
- Widths: lifetime and ms counter are W bits. hit_index values >= NUM_MOLES never match.
- mole_leds, mole_active and game_over are registered, decoded from state/pos registers; no combinational path from inputs.
- Async reset mid-game returns to the full reset state immediately, with no glitch on re-release.

Test Plan:
- TICKS_PER_MS=4, random_value=10, start: GAP lasts (200+10)*4 cycles ±1; SPAWN; mole_leds = 1<<10; mole_active = 1.
- random_value=25 at SPAWN: pos = 7; mole_leds = 18'h00080. Correct hit_index=7 after 3 ms: score = 1; lifetime = 950; back in GAP; mole_leds = 0.
- Wrong hit_index=3 while mole at 7: misses = 1; mole stays lit. No hit until expiry (1000 ms): misses = 2; GAP.
- Three expiries in a row with MAX_MISSES=3: state OVER; game_over = 1; further hit_valid pulses leave score/misses unchanged. start: clears both; enters GAP.
- Correct hit on the exact expiry cycle: score + 1, misses unchanged. 20 consecutive hits: lifetime floors at 250, never lower.
- enable dropped while in UP: IDLE next cycle, mole_leds = 0, score held. reset_n pulsed mid-GAP: all outputs 0 asynchronously.
